spi_adc_scanner: RTL and testbench
==================================

Name: spi_adc_scanner

Overview:
Parametrised multi-channel SPI ADC sampler, replacing the fixed single-channel 12-bit SPI reader. It scans the enabled channels round-robin: for each channel it sends the channel index over MOSI, captures DATA_W result bits from MISO, and emits each sample with its channel tag. It also keeps a per-channel power-of-two moving block average and per-channel over-threshold flags. It sits between the prescaled system clock domain and the LED / 7-segment display consumers.

Parameters:
DATA_W, 12, ADC result width (bits kept from end of frame)
NUM_CH, 4, number of ADC channels scanned
CH_W, 2, channel index width; must equal clog2(NUM_CH), minimum 1
FRAME_BITS, 16, SCK cycles per CS-low frame; must be >= DATA_W + CH_W
CLK_DIV, 4, clk cycles per SCK half-period; minimum 1
AVG_LOG2, 2, log2 of samples per average block; 0 means pass-through

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  level; continuous scanning while high
single  in  1  one-clk pulse; one full pass over enabled channels
ch_mask  in  NUM_CH  channel enable, bit i = channel i
thresh  in  DATA_W  over-threshold compare value, unsigned
MISO  in  1  ADC serial data out
SCK  out  1  SPI clock, mode 0 (idle low)
MOSI  out  1  SPI command data
CS  out  1  chip select, active low
busy  out  1  high from frame start until return to IDLE
o_data  out  DATA_W  latest sample
o_ch  out  CH_W  channel of o_data
o_valid  out  1  one-clk strobe, o_data/o_ch valid
o_avg  out  DATA_W  block average for channel o_ch
o_avg_valid  out  1  one-clk strobe, coincident with o_valid
o_over  out  NUM_CH  per-channel flag, last sample > thresh

Behaviour:
- Reset (asynchronous, effective immediately, including mid-frame): CS=1, SCK=0, MOSI=0, busy=0, o_valid=0, o_avg_valid=0, o_data=0, o_ch=0, o_avg=0, o_over=0. All accumulators and counters are cleared. The channel pointer is set so the first frame uses the lowest enabled channel.
- States: IDLE -> SETUP -> SHIFT -> HOLD -> STORE -> (SETUP or IDLE).
- IDLE: leave IDLE when (start=1 or single pulse seen) and ch_mask != 0. Select the next enabled channel after the last one, wrapping. ch_mask and channel are latched at SETUP entry. ch_mask=0 means remain in IDLE, with no frame and no strobes.
- SETUP: CS=0 for CLK_DIV clks. MOSI is presented with frame bit 0.
- SHIFT: FRAME_BITS SCK periods of 2*CLK_DIV clks each, SCK high in the second half. MISO is sampled on the clk where SCK rises. MOSI changes on SCK fall.
- MOSI frame: channel index MSB-first in bits 0..CH_W-1, then zeros.
- Data: the last DATA_W sampled bits, MSB first.
- HOLD: SCK=0, CS=1 for CLK_DIV clks.
- STORE (1 clk): registers o_data and o_ch and pulses o_valid on the following clk.
  - Updates o_over[ch] = (data > thresh), overwriting the previous value.
  - Adds data to acc[ch], which is DATA_W+AVG_LOG2 bits wide.
  - On the 2^AVG_LOG2-th sample of that channel: o_avg = acc >> AVG_LOG2 (truncating), o_avg_valid pulses with o_valid, and acc/count for that channel are cleared.
- Sample period with defaults: 4 + 128 + 4 + 1 = 137 clks.
- Continuation after STORE:
  - start=1: go to SETUP with the next enabled channel.
  - single pass: go to SETUP until the highest enabled channel is done, then IDLE.
- start falling mid-frame: the current frame completes, including STORE, then IDLE. A frame is never truncated.
- single while busy: ignored.
- ch_mask changes mid-frame take effect at the next SETUP. A channel that becomes disabled keeps its partial accumulator; it is not cleared.
- busy=1 from SETUP entry until IDLE re-entry.

Test Plan:
- Reset: hold rst_n=0, toggle MISO -> CS=1, SCK=0, o_* all 0. Assert rst_n=0 mid-SHIFT -> CS=1 and SCK=0 asynchronously; after release, the next frame restarts on the lowest enabled channel.
- single, ch_mask=4'b0001, ADC model returns 0xA5C -> 16 SCK rising edges; MOSI bits 0-1 = 00; o_data=0xA5C, o_ch=0, one o_valid; CS-low width 4+128 clks; busy low 1 clk after the strobe.
- start=1, ch_mask=4'b1010, model returns channel*0x100 -> o_ch sequence 1,3,1,3; o_data 0x100,0x300; MOSI first bits 01 then 11.
- Averaging, ch_mask=4'b0010, samples 100,200,300,400 -> o_avg_valid only on the 4th o_valid, o_avg=250. Next samples 1,1,1,2 -> o_avg=1 (truncation).
- Threshold, thresh=0x800, samples 0x801 then 0x800 on ch2 -> o_over[2]=1, then 0; other bits stay 0.
- ch_mask=0 with start=1 -> CS stays high, busy=0, no strobes. Deassert start mid-SHIFT -> the frame finishes, o_valid pulses once, then IDLE.

Source files
------------

// File: rtl/spi_adc_scanner.sv
`default_nettype none
// ============================================================================
// Module   : spi_adc_scanner
// Purpose  : Multi-channel SPI (mode 0) ADC sampler. Scans enabled channels
//            round-robin, sends the channel index on MOSI, captures DATA_W
//            result bits from MISO, and emits tagged samples together with a
//            per-channel power-of-two block average and over-threshold flags.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk, rst_n      system clock, asynchronous active-low reset
//   start           level, continuous scanning while high
//   single          one-clk pulse, one pass over the enabled channels
//   ch_mask         channel enables (bit i = channel i)
//   thresh          unsigned over-threshold compare value
//   MISO            ADC serial data in
//   SCK/MOSI/CS     SPI clock (idle low), command data, chip select (low)
//   busy            high from frame start until return to IDLE
//   o_data/o_ch     latest sample and its channel, qualified by o_valid
//   o_avg           block average for o_ch, qualified by o_avg_valid
//   o_over          per-channel flag, last sample > thresh
// ============================================================================
module spi_adc_scanner #(
    parameter int DATA_W     = 12,
    parameter int NUM_CH     = 4,
    parameter int CH_W       = 2,
    parameter int FRAME_BITS = 16,
    parameter int CLK_DIV    = 4,
    parameter int AVG_LOG2   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              single,
    input  logic [NUM_CH-1:0] ch_mask,
    input  logic [DATA_W-1:0] thresh,
    input  logic              MISO,
    output logic              SCK,
    output logic              MOSI,
    output logic              CS,
    output logic              busy,
    output logic [DATA_W-1:0] o_data,
    output logic [CH_W-1:0]   o_ch,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_avg,
    output logic              o_avg_valid,
    output logic [NUM_CH-1:0] o_over
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
    localparam int ACC_W = DATA_W + AVG_LOG2;
    localparam int CNT_W = AVG_LOG2 + 1;

    localparam logic [DIV_W-1:0] c_div_last = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] c_bit_last = BIT_W'(FRAME_BITS - 1);
    localparam logic [CNT_W-1:0] c_avg_last = CNT_W'((1 << AVG_LOG2) - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_SHIFT = 3'd2,
        S_HOLD  = 3'd3,
        S_STORE = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [DIV_W-1:0]    r_div;
    logic                r_phase;      // 0: SCK low half, 1: SCK high half
    logic [BIT_W-1:0]    r_bit;
    logic [DATA_W-1:0]   r_shift;
    logic [CH_W-1:0]     r_ch;         // channel of current / last frame
    logic                r_single;     // current run was started by single

    logic [ACC_W-1:0]    r_acc [NUM_CH];
    logic [CNT_W-1:0]    r_cnt [NUM_CH];

    logic                w_div_last;
    logic                w_enter_setup;
    logic                w_has_higher;
    logic [CH_W-1:0]     w_next_hi;
    logic [CH_W-1:0]     w_lowest;
    logic [CH_W-1:0]     w_next_ch;
    logic                w_mosi_bit;
    logic [ACC_W-1:0]    w_sum;

    assign w_div_last    = (r_div == c_div_last);
    assign w_enter_setup = (w_state_nxt == S_SETUP) && (r_state != S_SETUP);
    assign w_sum         = r_acc[r_ch] + ACC_W'(r_shift);

    // Next enabled channel after r_ch, wrapping to the lowest enabled one.
    // Scanning downwards leaves the smallest qualifying index in each result.
    always_comb begin
        w_has_higher = 1'b0;
        w_next_hi    = '0;
        w_lowest     = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (ch_mask[i]) begin
                w_lowest = CH_W'(i);
                if (CH_W'(i) > r_ch) begin
                    w_has_higher = 1'b1;
                    w_next_hi    = CH_W'(i);
                end
            end
        end
        w_next_ch = w_has_higher ? w_next_hi : w_lowest;
    end

    // Command frame: channel index MSB-first in bits 0..CH_W-1, zeros after.
    always_comb begin
        w_mosi_bit = 1'b0;
        for (int k = 0; k < CH_W; k++) begin
            if (r_bit == BIT_W'(k)) begin
                w_mosi_bit = r_ch[CH_W-1-k];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        CS          = 1'b1;
        SCK         = 1'b0;
        MOSI        = 1'b0;
        busy        = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                if ((start || single) && (|ch_mask)) begin
                    w_state_nxt = S_SETUP;
                end
            end
            S_SETUP: begin
                CS   = 1'b0;
                MOSI = w_mosi_bit;
                if (w_div_last) begin
                    w_state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                CS   = 1'b0;
                SCK  = r_phase;
                MOSI = w_mosi_bit;
                if (w_div_last && r_phase && (r_bit == c_bit_last)) begin
                    w_state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (w_div_last) begin
                    w_state_nxt = S_STORE;
                end
            end
            S_STORE: begin
                // A single pass ends once no enabled channel lies above this one.
                if ((|ch_mask) && (start || (r_single && w_has_higher))) begin
                    w_state_nxt = S_SETUP;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // SCK timing and MISO capture. MISO is shifted in on the clk that raises
    // SCK; the bit counter (and thus MOSI) advances on the clk that drops it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div   <= '0;
            r_phase <= 1'b0;
            r_bit   <= '0;
            r_shift <= '0;
        end else begin
            if (r_state == S_SETUP || r_state == S_SHIFT || r_state == S_HOLD) begin
                r_div <= w_div_last ? '0 : r_div + 1'b1;
            end else begin
                r_div <= '0;
            end
            if (r_state == S_SHIFT) begin
                if (w_div_last) begin
                    r_phase <= ~r_phase;
                    if (r_phase) begin
                        r_bit <= r_bit + 1'b1;
                    end else begin
                        r_shift <= {r_shift[DATA_W-2:0], MISO};
                    end
                end
            end else begin
                r_phase <= 1'b0;
                r_bit   <= '0;
            end
        end
    end

    // Channel pointer resets to the top index so the first frame after reset
    // wraps onto the lowest enabled channel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ch     <= CH_W'(NUM_CH - 1);
            r_single <= 1'b0;
        end else begin
            if (w_enter_setup) begin
                r_ch <= w_next_ch;
            end
            if (w_enter_setup && r_state == S_IDLE) begin
                r_single <= single;
            end
        end
    end

    // Result registers, threshold flags and block averaging. Accumulators of
    // channels that get disabled are left untouched until used again.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_data      <= '0;
            o_ch        <= '0;
            o_valid     <= 1'b0;
            o_avg       <= '0;
            o_avg_valid <= 1'b0;
            o_over      <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                r_acc[i] <= '0;
                r_cnt[i] <= '0;
            end
        end else begin
            o_valid     <= 1'b0;
            o_avg_valid <= 1'b0;
            if (r_state == S_STORE) begin
                o_data       <= r_shift;
                o_ch         <= r_ch;
                o_valid      <= 1'b1;
                o_over[r_ch] <= (r_shift > thresh);
                if (r_cnt[r_ch] == c_avg_last) begin
                    o_avg        <= DATA_W'(w_sum >> AVG_LOG2);
                    o_avg_valid  <= 1'b1;
                    r_acc[r_ch]  <= '0;
                    r_cnt[r_ch]  <= '0;
                end else begin
                    r_acc[r_ch]  <= w_sum;
                    r_cnt[r_ch]  <= r_cnt[r_ch] + 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_adc_scanner.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_adc_scanner
// Purpose  : Directed self-checking bench for spi_adc_scanner with a
//            behavioural mode-0 ADC model and an output strobe monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_adc_scanner;

    localparam int DATA_W     = 12;
    localparam int NUM_CH     = 4;
    localparam int CH_W       = 2;
    localparam int FRAME_BITS = 16;
    localparam int CLK_DIV    = 4;
    localparam int AVG_LOG2   = 2;

    logic              clk     = 1'b0;
    logic              rst_n   = 1'b0;
    logic              start   = 1'b0;
    logic              single  = 1'b0;
    logic [NUM_CH-1:0] ch_mask = '0;
    logic [DATA_W-1:0] thresh  = 12'hFFF;
    logic              miso    = 1'b0;
    logic              SCK, MOSI, CS, busy, o_valid, o_avg_valid;
    logic [DATA_W-1:0] o_data, o_avg;
    logic [CH_W-1:0]   o_ch;
    logic [NUM_CH-1:0] o_over;

    always #5 clk = ~clk;

    spi_adc_scanner #(
        .DATA_W(DATA_W), .NUM_CH(NUM_CH), .CH_W(CH_W),
        .FRAME_BITS(FRAME_BITS), .CLK_DIV(CLK_DIV), .AVG_LOG2(AVG_LOG2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .single(single),
        .ch_mask(ch_mask), .thresh(thresh), .MISO(miso),
        .SCK(SCK), .MOSI(MOSI), .CS(CS), .busy(busy),
        .o_data(o_data), .o_ch(o_ch), .o_valid(o_valid),
        .o_avg(o_avg), .o_avg_valid(o_avg_valid), .o_over(o_over)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- ADC model ----------------
    logic [DATA_W-1:0] samp_q[$];
    logic [DATA_W-1:0] cur_val = '0;
    bit                ch_mode = 1'b0;   // return channel*0x100 decoded from MOSI
    int                rc = 0;           // SCK rising edges in current frame
    logic [CH_W-1:0]   cap_ch = '0;
    int                last_rises = 0;
    logic [CH_W-1:0]   last_mosi_ch = '0;
    logic [CH_W-1:0]   mosi_q[$];

    function automatic logic [DATA_W-1:0] adc_value();
        return ch_mode ? {2'b00, cap_ch, 8'h00} : cur_val;
    endfunction

    function automatic logic frame_bit(input int k, input logic [DATA_W-1:0] v);
        if (k < FRAME_BITS - DATA_W || k >= FRAME_BITS) return 1'b0;
        return v[FRAME_BITS-1-k];
    endfunction

    always @(negedge CS) begin
        rc      = 0;
        cap_ch  = '0;
        cur_val = (samp_q.size() > 0) ? samp_q.pop_front() : 12'h000;
        miso    = frame_bit(0, adc_value());
    end
    always @(posedge SCK) begin
        if (rc < CH_W) cap_ch = {cap_ch[0], MOSI};
        rc++;
    end
    always @(negedge SCK) miso = frame_bit(rc, adc_value());
    always @(posedge CS) begin
        last_rises   = rc;
        last_mosi_ch = cap_ch;
        mosi_q.push_back(cap_ch);
    end

    // ---------------- output monitor ----------------
    typedef struct packed {
        logic [CH_W-1:0]   ch;
        logic [DATA_W-1:0] data;
        logic              av;
        logic [DATA_W-1:0] avg;
        logic [NUM_CH-1:0] over;
    } strobe_t;

    strobe_t st_q[$];
    int      cs_run = 0;
    int      last_cs_width = 0;
    int      cs_low_total = 0;
    bit      busy_seen = 1'b0;

    always @(negedge clk) begin
        if (o_valid) st_q.push_back(strobe_t'({o_ch, o_data, o_avg_valid, o_avg, o_over}));
        if (!CS) begin
            cs_run++;
            cs_low_total++;
        end else if (cs_run != 0) begin
            last_cs_width = cs_run;
            cs_run = 0;
        end
        if (busy) busy_seen = 1'b1;
    end

    function automatic strobe_t get_st(input int i);
        if (i < st_q.size()) return st_q[i];
        return '1;
    endfunction

    // ---------------- helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic wait_strobes(input string tag, input int n, input int budget);
        int k = 0;
        while (st_q.size() < n && k < budget) begin
            @(negedge clk); #1;
            k++;
        end
        check_eq({tag, "_strobe_wait"}, 32'(st_q.size() >= n), 32'd1);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int k = 0;
        while (busy && k < budget) begin
            @(negedge clk); #1;
            k++;
        end
        check_eq({tag, "_idle_wait"}, 32'(busy), 32'd0);
    endtask

    task automatic wait_mid_shift(input string tag, input int budget);
        int k = 0;
        while (!(!CS && rc >= 3 && SCK) && k < budget) begin
            @(negedge clk); #1;
            k++;
        end
        check_eq({tag, "_shift_wait"}, 32'(!CS && SCK), 32'd1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n  = 1'b0;
        start  = 1'b0;
        single = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        st_q.delete();
        mosi_q.delete();
        samp_q.delete();
        ch_mode   = 1'b0;
        busy_seen = 1'b0;
    endtask

    task automatic pulse_single();
        @(negedge clk) single = 1'b1;
        @(negedge clk) single = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- test sequence ----------------
    initial begin
        int cs_snap;
        strobe_t s;

        // Reset state while MISO toggles
        rst_n = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            miso = ~miso;
        end
        #1;
        check_eq("rst_cs", 32'(CS), 32'd1);
        check_eq("rst_sck", 32'(SCK), 32'd0);
        check_eq("rst_mosi", 32'(MOSI), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_valid", 32'(o_valid), 32'd0);
        check_eq("rst_avg_valid", 32'(o_avg_valid), 32'd0);
        check_eq("rst_data", 32'(o_data), 32'd0);
        check_eq("rst_ch", 32'(o_ch), 32'd0);
        check_eq("rst_avg", 32'(o_avg), 32'd0);
        check_eq("rst_over", 32'(o_over), 32'd0);
        do_reset();

        // Single pass, channel 0, 0xA5C
        ch_mask = 4'b0001;
        samp_q.push_back(12'hA5C);
        pulse_single();
        wait_strobes("single", 1, 400);
        s = get_st(0);
        check_eq("single_data", 32'(s.data), 32'hA5C);
        check_eq("single_ch", 32'(s.ch), 32'd0);
        check_eq("single_mosi_ch", 32'(last_mosi_ch), 32'd0);
        check_eq("single_sck_rises", 32'(last_rises), 32'd16);
        check_eq("single_cs_width", 32'(last_cs_width), 32'd132);
        tick(1);
        check_eq("single_busy_after", 32'(busy), 32'd0);
        check_eq("single_valid_after", 32'(o_valid), 32'd0);
        tick(300);
        check_eq("single_one_strobe", 32'(st_q.size()), 32'd1);

        // Continuous scan over channels 1 and 3
        do_reset();
        ch_mask = 4'b1010;
        ch_mode = 1'b1;
        start   = 1'b1;
        wait_strobes("scan", 4, 1000);
        for (int i = 0; i < 4; i++) begin
            s = get_st(i);
            check_eq($sformatf("scan_ch%0d", i), 32'(s.ch), (i % 2 == 0) ? 32'd1 : 32'd3);
            check_eq($sformatf("scan_data%0d", i), 32'(s.data), (i % 2 == 0) ? 32'h100 : 32'h300);
        end
        check_eq("scan_mosi0", 32'(mosi_q.size() > 0 ? mosi_q[0] : 2'bxx), 32'd1);
        check_eq("scan_mosi1", 32'(mosi_q.size() > 1 ? mosi_q[1] : 2'bxx), 32'd3);
        start = 1'b0;
        wait_idle("scan", 400);
        ch_mode = 1'b0;

        // Block averaging on channel 1
        do_reset();
        ch_mask = 4'b0010;
        samp_q.push_back(12'd100); samp_q.push_back(12'd200);
        samp_q.push_back(12'd300); samp_q.push_back(12'd400);
        samp_q.push_back(12'd1);   samp_q.push_back(12'd1);
        samp_q.push_back(12'd1);   samp_q.push_back(12'd2);
        start = 1'b1;
        wait_strobes("avg", 8, 1400);
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            s = get_st(i);
            check_eq($sformatf("avg_valid%0d", i), 32'(s.av), (i == 3 || i == 7) ? 32'd1 : 32'd0);
        end
        s = get_st(3);
        check_eq("avg_block1", 32'(s.avg), 32'd250);
        check_eq("avg_data4", 32'(s.data), 32'd400);
        s = get_st(7);
        check_eq("avg_block2_trunc", 32'(s.avg), 32'd1);
        wait_idle("avg", 400);

        // Over-threshold flag on channel 2
        do_reset();
        thresh  = 12'h800;
        ch_mask = 4'b0100;
        samp_q.push_back(12'h801);
        pulse_single();
        wait_strobes("thr_hi", 1, 400);
        s = get_st(0);
        check_eq("thr_hi_ch", 32'(s.ch), 32'd2);
        check_eq("thr_hi_over", 32'(s.over), 32'b0100);
        wait_idle("thr_hi", 50);
        samp_q.push_back(12'h800);
        pulse_single();
        wait_strobes("thr_eq", 2, 400);
        s = get_st(1);
        check_eq("thr_eq_data", 32'(s.data), 32'h800);
        check_eq("thr_eq_over", 32'(s.over), 32'b0000);
        wait_idle("thr_eq", 50);
        thresh = 12'hFFF;

        // Empty mask, then start dropped mid-frame
        do_reset();
        ch_mask = 4'b0000;
        start   = 1'b1;
        cs_snap = cs_low_total;
        tick(300);
        check_eq("nomask_cs_low", 32'(cs_low_total - cs_snap), 32'd0);
        check_eq("nomask_busy", 32'(busy_seen), 32'd0);
        check_eq("nomask_strobes", 32'(st_q.size()), 32'd0);
        samp_q.push_back(12'h123);
        ch_mask = 4'b0001;
        wait_mid_shift("stop", 300);
        start = 1'b0;
        wait_idle("stop", 300);
        check_eq("stop_strobes", 32'(st_q.size()), 32'd1);
        check_eq("stop_data", 32'(get_st(0).data), 32'h123);
        tick(300);
        check_eq("stop_no_more", 32'(st_q.size()), 32'd1);
        check_eq("stop_cs_high", 32'(CS), 32'd1);

        // Asynchronous reset in the middle of a channel-2 frame
        do_reset();
        ch_mask = 4'b1110;
        start   = 1'b1;
        wait_strobes("arst_first", 1, 400);
        check_eq("arst_first_ch", 32'(get_st(0).ch), 32'd1);
        wait_mid_shift("arst", 300);
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_cs", 32'(CS), 32'd1);
        check_eq("arst_sck", 32'(SCK), 32'd0);
        check_eq("arst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        st_q.delete();
        @(negedge clk) rst_n = 1'b1;
        wait_strobes("arst_next", 1, 400);
        check_eq("arst_next_ch", 32'(get_st(0).ch), 32'd1);
        check_eq("arst_next_mosi", 32'(last_mosi_ch), 32'd1);
        start = 1'b0;
        wait_idle("arst", 400);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
